// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the register file and its clear engine.
package regfile_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 32;

    // Upper bound on word width handled by merge_word; callers size-cast in and out.
    localparam int unsigned MaxWidth = 256;
    localparam int unsigned MaxBytes = MaxWidth / 8;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } clr_state_e;

    // Byte-wise merge: bytes with be[i]=1 come from new_word, the rest from old_word.
    function automatic logic [MaxWidth-1:0] merge_word(
        input logic [MaxWidth-1:0] old_word,
        input logic [MaxWidth-1:0] new_word,
        input logic [MaxBytes-1:0] be
    );
        logic [MaxWidth-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MaxBytes; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Write/read/clear bus of the register file; master drives requests, slave returns data.
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = $clog2(DEPTH)
) ();

    logic                 we;
    logic [AW-1:0]        waddr;
    logic [WIDTH/8-1:0]   wbe;
    logic [WIDTH-1:0]     data;
    logic [AW-1:0]        raddr_a;
    logic [AW-1:0]        raddr_b;
    logic [WIDTH-1:0]     dout_a;
    logic [WIDTH-1:0]     dout_b;
    logic                 clr_req;
    logic                 busy;
    logic                 clr_done;

    modport master (
        output we, waddr, wbe, data, raddr_a, raddr_b, clr_req,
        input  dout_a, dout_b, busy, clr_done
    );

    modport slave (
        input  we, waddr, wbe, data, raddr_a, raddr_b, clr_req,
        output dout_a, dout_b, busy, clr_done
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps addresses 0..DEPTH-1, one per cycle, then pulses clr_done.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req_i,
    output logic          clr_active_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          busy_o,
    output logic          clr_done_o
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    // State, sweep counter and registered busy/done flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clr_req_i) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    if (cnt_q == LastAddr) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // clr_req is not sampled here; a held request re-arms from IDLE.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_active_o = (state_q == StClear);
    assign clr_addr_o   = cnt_q;
    assign busy_o       = busy_q;
    assign clr_done_o   = done_q;

endmodule

// File: rtl/register_file.sv
// Multi-port register file: one byte-enabled write port, two combinational read ports,
// and a sequenced bulk clear. Define REGFILE_BYPASS_EN to forward a same-cycle write
// to a matching read port.
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus_io
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             clr_active;
    logic [AW-1:0]    clr_addr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Address is backed by storage: in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
    endfunction

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk          (clk),
        .reset        (reset),
        .clr_req_i    (bus_io.clr_req),
        .clr_active_o (clr_active),
        .clr_addr_o   (clr_addr),
        .busy_o       (bus_io.busy),
        .clr_done_o   (bus_io.clr_done)
    );

    // Write qualification and the post-write word (used for storage and forwarding).
    always_comb begin
        wr_en   = bus_io.we && !clr_active && addr_ok(bus_io.waddr);
        wr_old  = addr_ok(bus_io.waddr) ? mem_q[bus_io.waddr] : '0;
        wr_word = WIDTH'(merge_word(MaxWidth'(wr_old), MaxWidth'(bus_io.data),
                                    MaxBytes'(bus_io.wbe)));
    end

    // Storage: clear sweep has priority, writes are already blocked while clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clr_active && (32'(clr_addr) == i)) begin
                    mem_q[i] <= '0;
                end else if (wr_en && (32'(bus_io.waddr) == i)) begin
                    mem_q[i] <= wr_word;
                end
            end
        end
    end

    // Read muxes, with optional write-through forwarding.
    always_comb begin
        rd_a = addr_ok(bus_io.raddr_a) ? mem_q[bus_io.raddr_a] : '0;
        rd_b = addr_ok(bus_io.raddr_b) ? mem_q[bus_io.raddr_b] : '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus_io.waddr == bus_io.raddr_a)) begin
            rd_a = wr_word;
        end
        if (wr_en && (bus_io.waddr == bus_io.raddr_b)) begin
            rd_b = wr_word;
        end
`endif
        bus_io.dout_a = rd_a;
        bus_io.dout_b = rd_b;
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: the driver pushes expected outputs computed from a
// behavioural model; a negedge monitor pops and compares. Honors REGFILE_BYPASS_EN.
module tb_register_file;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_if #(.WIDTH(W), .DEPTH(D)) bus ();

    register_file #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ZERO_REG (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: plain array plus "entries left to clear" and a done-cycle flag.
    logic [W-1:0] ref_mem [D];
    int           clr_left;
    bit           done_cycle;

    function automatic logic [W-1:0] after_write(input logic [W-1:0] old_w,
                                                  input logic [W-1:0] new_w,
                                                  input logic [3:0] be);
        logic [W-1:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    function automatic bool_addr(input int addr);
        return (addr > 0) && (addr < D);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        clr_left   = 0;
        done_cycle = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_read(input int ra, input bit we_v, input int wa,
                                               input logic [3:0] be, input logic [W-1:0] d);
        logic [W-1:0] v;
        v = bool_addr(ra) ? ref_mem[ra] : '0;
`ifdef REGFILE_BYPASS_EN
        if (we_v && clr_left == 0 && bool_addr(wa) && wa == ra) v = after_write(v, d, be);
`else
        if (we_v && wa < 0) v = '0;
`endif
        return v;
    endfunction

    task automatic model_edge(input bit we_v, input int wa, input logic [3:0] be,
                              input logic [W-1:0] d, input bit clr);
        if (clr_left > 0) begin
            ref_mem[D - clr_left] = '0;
            clr_left--;
            done_cycle = (clr_left == 0);
        end else begin
            if (we_v && bool_addr(wa)) ref_mem[wa] = after_write(ref_mem[wa], d, be);
            if (done_cycle) done_cycle = 1'b0;
            else if (clr) clr_left = D;
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, want);
        end
    endtask

    // One cycle: drive just after posedge, queue expectation, advance model at the edge.
    task automatic step(input bit rst_v, input bit we_v, input int wa, input logic [3:0] be,
                        input logic [W-1:0] d, input int ra, input int rb, input bit clr,
                        input string tag);
        exp_t e;
        reset       = rst_v;
        bus.we      = we_v;
        bus.waddr   = wa[AW-1:0];
        bus.wbe     = be;
        bus.data    = d;
        bus.raddr_a = ra[AW-1:0];
        bus.raddr_b = rb[AW-1:0];
        bus.clr_req = clr;
        if (rst_v) model_reset();
        e.tag  = tag;
        e.a    = exp_read(ra, we_v, wa, be, d);
        e.b    = exp_read(rb, we_v, wa, be, d);
        e.busy = (clr_left > 0);
        e.done = done_cycle;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst_v) model_edge(we_v, wa, be, d, clr);
        #1;
    endtask

    task automatic fill_all();
        for (int i = 1; i < D; i++) begin
            step(0, 1, i, 4'hF, $urandom | 32'h1, $urandom_range(0, D - 1), i, 0, "fill");
        end
    endtask

    task automatic read_sweep(input string tag);
        for (int i = 0; i < D; i += 2) begin
            step(0, 0, 0, 4'h0, '0, i, i + 1, 0, $sformatf("%s%0d", tag, i));
        end
    endtask

    // Monitor: compare every presented output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".dout_a"}, bus.dout_a, e.a);
                check({e.tag, ".dout_b"}, bus.dout_b, e.b);
                check({e.tag, ".busy"}, W'(bus.busy), W'(e.busy));
                check({e.tag, ".clr_done"}, W'(bus.clr_done), W'(e.done));
            end
        end
    end

    // Driver.
    initial begin
        reset       = 1'b1;
        bus.we      = 1'b0;
        bus.waddr   = '0;
        bus.wbe     = '0;
        bus.data    = '0;
        bus.raddr_a = '0;
        bus.raddr_b = '0;
        bus.clr_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 4'h0, '0, 0, 5, 0, "reset_state");

        step(0, 1, 5, 4'hF, 32'h3, 5, 0, 0, "wr_r5_3");
        step(0, 1, 5, 4'hF, 32'h2, 5, 5, 0, "wr_r5_2");
        step(0, 0, 0, 4'h0, '0, 5, 5, 0, "rd_r5");

        step(0, 1, 7, 4'hF, 32'hAABBCCDD, 7, 0, 0, "wr_r7_full");
        step(0, 1, 7, 4'b0101, 32'h11223344, 7, 7, 0, "wr_r7_be");
        step(0, 0, 0, 4'h0, '0, 7, 7, 0, "rd_r7_merge");

        step(0, 1, 0, 4'hF, 32'hFFFFFFFF, 0, 0, 0, "wr_r0");
        step(0, 0, 0, 4'h0, '0, 0, 0, 0, "rd_r0");

        step(0, 1, 9, 4'hF, 32'hDEAD0000, 1, 2, 0, "wr_r9_old");
        step(0, 1, 9, 4'hF, 32'h5, 9, 9, 0, "bypass_r9");
        step(0, 0, 0, 4'h0, '0, 9, 9, 0, "rd_r9");

        // Full clear with a write attempt while busy and a write in the DONE cycle.
        fill_all();
        step(0, 0, 0, 4'h0, '0, 3, 4, 1, "clr_req");
        for (int i = 0; i < D; i++) begin
            step(0, (i == 5), 3, 4'hF, 32'hFFFFFFFF, 3, i, 0, $sformatf("clr_sweep%0d", i));
        end
        step(0, 1, 4, 4'hF, 32'h1234, 4, 3, 0, "done_wr_r4");
        step(0, 0, 0, 4'h0, '0, 4, 3, 0, "after_done");
        read_sweep("post_clr");

        // Async reset when the sweep counter sits at 10.
        fill_all();
        step(0, 0, 0, 4'h0, '0, 20, 31, 1, "clr_req2");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 4'h0, '0, 20, i, 0, $sformatf("clr2_sweep%0d", i));
        end
        step(1, 0, 0, 4'h0, '0, 20, 31, 0, "async_rst");
        read_sweep("post_rst");
        step(0, 0, 0, 4'h0, '0, 1, 2, 0, "idle_after_rst");

        // Randomized traffic, including occasional clear requests.
        for (int n = 0; n < 300; n++) begin
            int wa;
            int ra;
            wa = $urandom_range(0, D - 1);
            ra = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, D - 1);
            step(0, ($urandom_range(0, 2) != 0), wa, 4'($urandom_range(0, 15)), $urandom,
                 ra, $urandom_range(0, D - 1), ($urandom_range(0, 49) == 0),
                 $sformatf("rand%0d", n));
        end
        step(0, 0, 0, 4'h0, '0, 0, 1, 0, "final");

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
